// File: rtl/alu_mc_pkg.sv
// Shared opcode constants, FSM state encoding and opcode decode for alu_mc.
// ALU_MC_MUL_EN adds the iterative-multiply state to the enumeration.
package alu_mc_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
`ifdef ALU_MC_MUL_EN
        ST_MUL  = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SL_AND  = 2'd0,
        SL_OR   = 2'd1,
        SL_ADD  = 2'd2,
        SL_LESS = 2'd3
    } slice_op_e;

    typedef struct packed {
        logic      valid;
        logic      arith;
        logic      a_inv;
        logic      b_inv;
        slice_op_e op;
    } op_ctrl_t;

    // NOR is ~a & ~b; SUB/SLT reuse the adder with b inverted and carry-in 1.
    function automatic op_ctrl_t decode_op(input logic [3:0] ctrl);
        op_ctrl_t c;
        c.valid = 1'b1;
        c.arith = 1'b0;
        c.a_inv = 1'b0;
        c.b_inv = 1'b0;
        c.op    = SL_AND;
        case (ctrl)
            OP_AND: c.op = SL_AND;
            OP_OR:  c.op = SL_OR;
            OP_ADD: begin c.arith = 1'b1; c.op = SL_ADD; end
            OP_SUB: begin c.arith = 1'b1; c.b_inv = 1'b1; c.op = SL_ADD; end
            OP_SLT: begin c.arith = 1'b1; c.b_inv = 1'b1; c.op = SL_LESS; end
            OP_NOR: begin c.a_inv = 1'b1; c.b_inv = 1'b1; c.op = SL_AND; end
            default: c.valid = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ALU: optional operand inversion, AND/OR/full-add, and a
// pass-through "less" input used to assemble the SLT result.
module alu_bit_slice
    import alu_mc_pkg::*;
(
    input  logic      a_i,
    input  logic      b_i,
    input  logic      a_invert_i,
    input  logic      b_invert_i,
    input  logic      carry_i,
    input  logic      less_i,
    input  slice_op_e op_i,
    output logic      res_o,
    output logic      carry_o
);

    logic a_eff;
    logic b_eff;
    logic sum;

    assign a_eff   = a_i ^ a_invert_i;
    assign b_eff   = b_i ^ b_invert_i;
    assign sum     = a_eff ^ b_eff ^ carry_i;
    assign carry_o = (a_eff & b_eff) | (carry_i & (a_eff ^ b_eff));

    always_comb begin
        // NOTE: default first so every path assigns res_o and no latch is inferred.
        res_o = 1'b0;
        case (op_i)
            SL_AND:  res_o = a_eff & b_eff;
            SL_OR:   res_o = a_eff | b_eff;
            SL_ADD:  res_o = sum;
            SL_LESS: res_o = less_i;
            default: res_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: one-cycle logic/arith ops on a ripple slice chain, and an
// optional WIDTH-cycle shift-add multiplier compiled in by ALU_MC_MUL_EN.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e             state_q, state_d;
    logic [3:0]         ctrl_q;
    logic [WIDTH-1:0]   src1_q, src2_q;
    logic [WIDTH-1:0]   result_q, res_d;
    logic               zero_q, cout_q, ovf_q;
    logic               cout_d, ovf_d;
    logic               load_ops, res_we;

    op_ctrl_t           dec;
    logic [WIDTH-1:0]   res_w;
    logic               msb_cin_w, chain_cout_w;
    logic               ovf_w, slt_w;

    assign dec = decode_op(ctrl_q);

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic cin;
        logic cout;
        if (i == 0) begin : g_lsb
            assign cin = dec.b_inv;
        end else begin : g_rest
            assign cin = g_slice[i-1].cout;
        end
        alu_bit_slice u_slice (
            .a_i        (src1_q[i]),
            .b_i        (src2_q[i]),
            .a_invert_i (dec.a_inv),
            .b_invert_i (dec.b_inv),
            .carry_i    (cin),
            .less_i     ((i == 0) ? slt_w : 1'b0),
            .op_i       (dec.op),
            .res_o      (res_w[i]),
            .carry_o    (cout)
        );
    end

    assign msb_cin_w    = g_slice[WIDTH-1].cin;
    assign chain_cout_w = g_slice[WIDTH-1].cout;
    assign ovf_w        = msb_cin_w ^ chain_cout_w;
    // Signed less-than: MSB of the difference, corrected by signed overflow.
    assign slt_w = (src1_q[WIDTH-1] ^ dec.a_inv) ^ (src2_q[WIDTH-1] ^ dec.b_inv)
                 ^ msb_cin_w ^ ovf_w;

`ifdef ALU_MC_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod_q, prod_step;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     mul_sum;

    // Product register holds {partial sum, remaining multiplier bits}.
    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, src1_q} : '0);
    assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};
`endif

    always_comb begin
        state_d  = state_q;
        load_ops = 1'b0;
        res_we   = 1'b0;
        res_d    = dec.valid ? res_w : '0;
        cout_d   = dec.arith & chain_cout_w;
        ovf_d    = dec.arith & ovf_w;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load_ops = 1'b1;
`ifdef ALU_MC_MUL_EN
                    state_d  = (ctrl_i == OP_MUL) ? ST_MUL : ST_EXEC;
`else
                    state_d  = ST_EXEC;
`endif
                end
            end
            ST_EXEC: begin
                res_we  = 1'b1;
                state_d = ST_DONE;
            end
`ifdef ALU_MC_MUL_EN
            ST_MUL: begin
                res_d  = prod_step[WIDTH-1:0];
                cout_d = 1'b0;
                ovf_d  = |prod_step[2*WIDTH-1:WIDTH];
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_we  = 1'b1;
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            if (load_ops) begin
                ctrl_q <= ctrl_i;
                src1_q <= src1_i;
                src2_q <= src2_i;
            end
            if (res_we) begin
                result_q <= res_d;
                zero_q   <= (res_d == '0);
                cout_q   <= cout_d;
                ovf_q    <= ovf_d;
            end
        end
    end

`ifdef ALU_MC_MUL_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            cnt_q  <= '0;
        end else if (load_ops) begin
            prod_q <= {{WIDTH{1'b0}}, src2_i};
            cnt_q  <= '0;
        end else if (state_q == ST_MUL) begin
            prod_q <= prod_step;
            cnt_q  <= cnt_q + 1'b1;
        end
    end
`endif

    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32); MUL vectors are used
// when ALU_MC_MUL_EN is defined, the MUL-as-NOP vectors otherwise.
module tb_alu_mc;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i, src2_i;
    logic [31:0] result_o;
    logic        zero_o, cout_o, overflow_o, busy_o, done_o;

    int n_checks = 0;
    int n_fails  = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .ctrl_i     (ctrl_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, result_o, 32'h0);
        check({tag, "_zero"}, zero_o, 1'b0);
        check({tag, "_cout"}, cout_o, 1'b0);
        check({tag, "_ovf"}, overflow_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_done"}, done_o, 1'b0);
    endtask

    // Issues one operation; lat counts negedges after the start edge until done_o.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int lat);
        @(negedge clk_i);
        ctrl_i  = op;
        src1_i  = a;
        src2_i  = b;
        start_i = 1'b1;
        lat     = 0;
        do begin
            @(negedge clk_i);
            if (!hold) start_i = 1'b0;
            if (lat == 0) begin
                ctrl_i = ~op;
                src1_i = ~a;
                src2_i = ~b;
            end
            lat++;
        end while (!done_o && lat < 100);
        start_i = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit hold, input logic [31:0] e_res,
                            input logic e_z, input logic e_c, input logic e_v, input int e_lat);
        int lat;
        do_op(op, a, b, hold, lat);
        check({tag, "_done"}, done_o, 1'b1);
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_result"}, result_o, e_res);
        check({tag, "_zero"}, zero_o, e_z);
        check({tag, "_cout"}, cout_o, e_c);
        check({tag, "_ovf"}, overflow_o, e_v);
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk_i);
            if (done_o) cnt++;
        end
    endtask

    initial begin
        int cnt;
        rst_n   = 1'b0;
        start_i = 1'b0;
        ctrl_i  = 4'h0;
        src1_i  = '0;
        src2_i  = '0;

        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
        check("idle_busy", busy_o, 1'b0);
        check("idle_done", done_o, 1'b0);

        // Consecutive calls start in the cycle right after done (back-to-back).
        op_check("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 0, 0, 1, 2);
        op_check("sub_eq",   4'b0110, 32'h0000_0005, 32'h0000_0005, 0, 32'h0000_0000, 1, 1, 0, 2);
        op_check("slt_m1_1", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0001, 0, 1, 0, 2);
        op_check("slt_1_m1", 4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1, 0, 0, 2);
        op_check("and_ones", 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 0, 0, 2);
        op_check("or",       4'b0001, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 32'hFFF0_FFFF, 0, 0, 0, 2);
        op_check("nor",      4'b1100, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 32'h000F_0000, 0, 0, 0, 2);
        op_check("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1, 1, 0, 2);
        op_check("sub_ovf",  4'b0110, 32'h8000_0000, 32'h0000_0001, 0, 32'h7FFF_FFFF, 0, 1, 1, 2);
        op_check("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 32'h00F0_1234, 0, 0, 0, 2);
        op_check("undef",    4'b0011, 32'h0000_0005, 32'h0000_0005, 0, 32'h0000_0000, 1, 0, 0, 2);

`ifdef ALU_MC_MUL_EN
        op_check("mul_big",  4'b1000, 32'h0001_0000, 32'h0001_0000, 0, 32'h0000_0000, 1, 0, 1, 33);
        op_check("mul_7x6",  4'b1000, 32'h0000_0007, 32'h0000_0006, 0, 32'h0000_002A, 0, 0, 0, 33);
        op_check("mul_hold", 4'b1000, 32'hFFFF_FFFF, 32'h0000_0002, 1, 32'hFFFF_FFFE, 0, 0, 1, 33);
        count_done(40, cnt);
        check("hold_extra_done", cnt, 0);
        check("hold_stable", result_o, 32'hFFFF_FFFE);

        @(negedge clk_i);
        ctrl_i  = 4'b1000;
        src1_i  = 32'h0000_0003;
        src2_i  = 32'h0000_0005;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check("abort_busy_before", busy_o, 1'b1);
`else
        op_check("add_small", 4'b0010, 32'h0000_0001, 32'h0000_0002, 0, 32'h0000_0003, 0, 0, 0, 2);
        op_check("mul_nop",   4'b1000, 32'h0000_0003, 32'h0000_0003, 0, 32'h0000_0000, 1, 0, 0, 2);
        op_check("add_hold",  4'b0010, 32'h0000_0001, 32'h0000_0001, 1, 32'h0000_0002, 0, 0, 0, 2);
        count_done(40, cnt);
        check("hold_extra_done", cnt, 0);
        check("hold_stable", result_o, 32'h0000_0002);

        @(negedge clk_i);
        ctrl_i  = 4'b0010;
        src1_i  = 32'h0000_0009;
        src2_i  = 32'h0000_0009;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("abort_busy_before", busy_o, 1'b1);
`endif
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk_i);
        rst_n = 1'b1;
        count_done(40, cnt);
        check("abort_no_done", cnt, 0);
        op_check("add_after", 4'b0010, 32'h1234_5678, 32'h1111_1111, 0, 32'h2345_6789, 0, 0, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 4..64).
REQ-002 SHALL have port clk_i  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port ctrl_i  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL.
REQ-006 SHALL have ports src1_i and src2_i  input  WIDTH  operands.
REQ-007 SHALL have port result_o  output  WIDTH  registered result.
REQ-008 SHALL have ports zero_o, cout_o and overflow_o  output  1  each  registered flags.
REQ-009 SHALL have ports busy_o  output  1  (operation in progress) and done_o  output  1  (one-cycle completion pulse).

Function
REQ-010 SHALL implement the states IDLE, EXEC, MUL and DONE.
REQ-011 SHALL, in IDLE with start_i=1, capture ctrl_i, src1_i and src2_i, then go to MUL for opcode 1000 and to EXEC otherwise.
REQ-012 SHALL, in EXEC, compute the result and flags, register them, and go to DONE; done_o then rises exactly 2 cycles after the start edge.
REQ-013 SHALL perform SUB and SLT as src1 + ~src2 + 1, using the same WIDTH-bit add chain as ADD.
REQ-014 SHALL set SLT result to {0, (sign of difference) XOR overflow}, i.e. the signed less-than.
REQ-015 SHALL set cout_o to the carry out of the add chain for ADD/SUB/SLT, and to 0 for all other opcodes.
REQ-016 SHALL set overflow_o to the signed overflow for ADD/SUB/SLT, and to 0 for all other opcodes.
REQ-017 SHALL set zero_o to 1 exactly when result_o equals 0, for every opcode.
REQ-018 SHALL, in MUL, run unsigned shift-add for exactly WIDTH iterations (one bit per cycle), then go to DONE; result_o is the low WIDTH bits of the product.
REQ-019 SHALL, in MUL, set overflow_o to 1 when any upper product bit is nonzero, and set cout_o to 0.
REQ-020 SHALL, in DONE, drive done_o=1 for exactly one cycle and then return to IDLE.
REQ-021 SHALL hold busy_o=1 in the states EXEC, MUL and DONE.
REQ-022 SHALL ignore start_i whenever the block is not in IDLE.
REQ-023 SHALL hold result_o and the flags stable from DONE until the next DONE.
REQ-024 SHALL treat an undefined opcode as AND-free NOP: result 0, zero_o=1, other flags 0, normal EXEC latency.
REQ-025 SHALL accept start_i in the cycle immediately after done_o (back-to-back operations).

Reset
REQ-026 SHALL, on rst_n low, immediately force: state IDLE, result_o=0, zero_o=0, cout_o=0, overflow_o=0, busy_o=0, done_o=0.
REQ-027 SHALL abort any in-flight MUL when reset asserts, and produce no done_o afterwards.

Configuration
REQ-028 SHALL use the macro ALU_MC_MUL_EN to compile the iterative multiplier in or out.
REQ-029 SHALL, with ALU_MC_MUL_EN defined, implement MUL as in REQ-018 and REQ-019.
REQ-030 SHALL, without ALU_MC_MUL_EN, omit the MUL state and multiplier registers, and treat opcode 1000 as undefined per REQ-024.

Structure
REQ-031 SHALL take the opcode constants and the state enumeration from the shared package alu_mc_pkg.
REQ-032 SHALL build the add chain from WIDTH instances of the sub-module alu_bit_slice (1-bit AND/OR/add with invert controls and less input).

Verification
REQ-033 SHALL cover: WIDTH=32, ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, cout=0, done 2 cycles after start.
REQ-034 SHALL cover: SUB 5-5 -> result 0, zero=1, cout=1; SLT -1 vs 1 -> result 1; SLT 1 vs -1 -> result 0.
REQ-035 SHALL cover: MUL 0x10000 x 0x10000 -> result 0, overflow=1, done exactly 33 cycles after start; MUL 7 x 6 -> 42, overflow=0.
REQ-036 SHALL cover: start_i held high during MUL -> exactly one done pulse; start_i on the cycle after done -> second operation accepted.
REQ-037 SHALL cover: rst_n low at the 10th MUL cycle -> all outputs 0 immediately, no done; a new ADD afterwards completes normally.
REQ-038 SHALL cover: build without ALU_MC_MUL_EN, MUL 3 x 3 -> result 0, zero=1, done after 2 cycles.
